// File: rtl/pipe_chain_pkg.sv
// Shared types and helpers for pipe_stage_chain.
//   stage_act_e : per-stage register action chosen by the top-level decode
//   CNT_W/CNT_MAX : width and saturation value of the statistics counters
//   sat_inc     : saturating increment used by the statistics counters
package pipe_chain_pkg;

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } stage_act_e;

  // Increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One pipeline register (payload + valid) driven by a decoded action.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   act                   action for this edge (advance/hold/bubble/flush)
//   prev_data, prev_valid contents of the upstream stage (or chain input)
//   data, valid           registered contents of this stage
module pipe_chain_stage
  import pipe_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  stage_act_e       act,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Next-state select; bubbles and flushes always carry zero payload.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (act)
      ACT_ADVANCE: begin
        data_d  = prev_data;
        valid_d = prev_valid;
      end
      ACT_BUBBLE, ACT_FLUSH: begin
        data_d  = '0;
        valid_d = 1'b0;
      end
      default: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of STAGES pipeline registers with per-stage stall/flush
// and valid tracking. A stall in stage k freezes stages 0..k and inserts a
// bubble into stage k+1; flush clears a stage even while it is held.
// Optional statistics counters are built when PIPE_CHAIN_STATS_EN is defined.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_data, in_valid      beat entering stage 0
//   in_ready               stage 0 accepts this cycle
//   stall, flush           per-stage stall / flush requests
//   stage_data/stage_valid every stage's contents (stage i at [i*WIDTH +: WIDTH])
//   out_data/out_valid     last stage contents
//   stall_cnt, bubble_cnt  (PIPE_CHAIN_STATS_EN) saturating cycle counters
module pipe_stage_chain
  import pipe_chain_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic [STAGES-1:0]         stage_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid
`ifdef PIPE_CHAIN_STATS_EN
  ,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
`endif
);

  logic [STAGES-1:0] hold;

  // Back-pressure: a stall propagates to every upstream stage.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  assign in_ready = ~hold[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    stage_act_e       act_c;
    logic             up_hold;
    logic [WIDTH-1:0] prev_data;
    logic             prev_valid;

    if (g == 0) begin : g_first
      assign up_hold    = 1'b0;
      assign prev_data  = in_data;
      assign prev_valid = in_valid;
    end else begin : g_rest
      assign up_hold    = hold[g-1];
      assign prev_data  = stage_data[(g-1)*WIDTH +: WIDTH];
      assign prev_valid = stage_valid[g-1];
    end

    // Priority: flush > hold > bubble (upstream frozen) > advance.
    always_comb begin
      act_c = ACT_ADVANCE;
      if (flush[g])      act_c = ACT_FLUSH;
      else if (hold[g])  act_c = ACT_HOLD;
      else if (up_hold)  act_c = ACT_BUBBLE;
    end

    pipe_chain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .act        (act_c),
      .prev_data  (prev_data),
      .prev_valid (prev_valid),
      .data       (stage_data[g*WIDTH +: WIDTH]),
      .valid      (stage_valid[g])
    );
  end

  assign out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];
  assign out_valid = stage_valid[STAGES-1];

`ifdef PIPE_CHAIN_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Count cycles with stage 0 blocked and cycles with an empty output.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!in_ready)  stall_cnt_d  = sat_inc(stall_cnt_q);
    if (!out_valid) bubble_cnt_d = sat_inc(bubble_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
